// File: rtl/pattern_grant_pkg.sv
// Shared types and default parameters for the pattern-triggered grant controller.
package pattern_grant_pkg;

    localparam int unsigned DEF_PAT_LEN = 3;
    localparam logic [2:0]  DEF_PAT     = 3'b101;
    localparam int unsigned DEF_Y_WIN   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFpulse,
        StMon,
        StGwait,
        StGhold,
        StGfail
    } state_e;

endpackage

// File: rtl/x_pattern_match.sv
// Sliding-window matcher: compares the last PAT_LEN samples of x (newest in the LSB) with PAT.
module x_pattern_match
    import pattern_grant_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PAT     = PAT_LEN'(DEF_PAT)
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic match
);

    if (PAT_LEN > 1) begin : g_hist
        logic [PAT_LEN-2:0] hist_q;
        logic [PAT_LEN-1:0] window;

        assign window = {hist_q, x};
        assign match  = (window == PAT);

        always_ff @(posedge clk) begin
            if (clr) begin
                hist_q <= '0;
            end else if (en) begin
                hist_q <= window[PAT_LEN-2:0];
            end
        end
    end else begin : g_nohist
        // Single-bit pattern needs no storage, so the control inputs go unused.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, clr, en};
        assign match       = (x == PAT[0]);
    end

endmodule

// File: rtl/pattern_grant_fsm.sv
// Start pulse, watch x for PAT, grant g and wait up to Y_WIN cycles for y confirmation.
module pattern_grant_fsm
    import pattern_grant_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PAT     = PAT_LEN'(DEF_PAT),
    parameter int unsigned          Y_WIN   = DEF_Y_WIN
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic y,
    input  logic rearm,
    output logic f,
    output logic g,
    output logic pass,
    output logic fail
);

    localparam int unsigned    CntW    = $clog2(Y_WIN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(Y_WIN - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            match;
    logic            hist_clr;
    logic            hist_en;

    // History restarts on reset and on every pass through FPULSE, i.e. on each entry to MON.
    assign hist_clr = reset || (state_q == StFpulse);
    assign hist_en  = (state_q == StMon);

    x_pattern_match #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT)
    ) u_x_pattern_match (
        .clk   (clk),
        .clr   (hist_clr),
        .en    (hist_en),
        .x     (x),
        .match (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:   state_d = StFpulse;
            StFpulse: state_d = StMon;
            StMon: begin
                if (match) begin
                    state_d = StGwait;
                    cnt_d   = '0;
                end
            end
            StGwait: begin
                // y is checked first so a confirmation on the last window cycle still passes.
                if (y) begin
                    state_d = StGhold;
                end else if (cnt_q == CntLast) begin
                    state_d = StGfail;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGhold, StGfail: begin
                if (rearm) begin
                    state_d = StFpulse;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        f    = (state_q == StFpulse);
        g    = (state_q == StGwait) || (state_q == StGhold);
        pass = (state_q == StGhold);
        fail = (state_q == StGfail);
    end

endmodule
